// File: rtl/hmmm_mem_responder.sv
// hmmm_mem_responder: program store for a small processor on a two-phase clock.
// A byte-serial loader fills the word array (high byte, then low byte) while the
// processor is held; afterwards the processor reads whole words combinationally
// and may overwrite the low byte of any word.
//
// Timing model: next state is computed from the ph1-stage state and the inputs,
// captured at the end of ph2 (falling edge), and copied to the visible state
// registers on the rising edge of ph1. Array writes land at the same ph2 edge.
module hmmm_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 15
) (
    input  logic              ph1,
    input  logic              ph2,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic              cpu_memwrite,
    input  logic [7:0]        cpu_wdata,
    output logic [WORD_W-9:0] cpu_rdata_hi,
    output logic [7:0]        cpu_rdata_lo,
    output logic              cpu_rdata_lo_oe,
    output logic              cpu_hold,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic [ADDR_W-1:0] ld_count,
    output logic              ld_err
);

    localparam int HI_W  = WORD_W - 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_LOAD_HI = 2'd0;
    localparam logic [1:0] S_LOAD_LO = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    // Word storage is split into two arrays so the processor's low-byte write
    // never has to read back and rewrite the high field.
    logic [HI_W-1:0] mem_hi [DEPTH];
    logic [7:0]      mem_lo [DEPTH];

    // Visible (ph1) state
    logic [1:0]        state_q;
    logic [ADDR_W-1:0] count_q;
    logic              err_q;
    logic [HI_W-1:0]   hi_q;

    // ph2-captured state, handed to the ph1 stage
    logic [1:0]        state_p2_q;
    logic [ADDR_W-1:0] count_p2_q;
    logic              err_p2_q;
    logic [HI_W-1:0]   hi_p2_q;

    // Next-state values
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] count_d;
    logic              err_d;
    logic [HI_W-1:0]   hi_d;
    logic              ld_wr;
    logic              cpu_wr;

    logic run;
    logic xfer;

    assign run  = (state_q == S_RUN);
    assign xfer = ld_valid & ~run;

    // Next-state and write-enable decode for one ph1+ph2 cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        hi_d    = hi_q;
        ld_wr   = 1'b0;
        cpu_wr  = 1'b0;
        if (reset) begin
            state_d = S_LOAD_HI;
            count_d = '0;
            err_d   = 1'b0;
            hi_d    = '0;
        end else begin
            case (state_q)
                S_LOAD_HI: begin
                    if (xfer) begin
                        hi_d    = ld_byte[HI_W-1:0];
                        state_d = S_LOAD_LO;
                    end
                    // A high byte accepted together with done leaves a
                    // half word behind, which is the same error as done in LOAD_LO.
                    if (ld_done) begin
                        state_d = S_RUN;
                        if (xfer) err_d = 1'b1;
                    end
                end
                S_LOAD_LO: begin
                    if (xfer) begin
                        ld_wr   = 1'b1;
                        count_d = count_q + 1'b1;
                        state_d = (count_q == '1) ? S_RUN : S_LOAD_HI;
                    end
                    if (ld_done) begin
                        state_d = S_RUN;
                        if (!xfer) err_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (ld_valid) err_d = 1'b1;
                    cpu_wr = cpu_memwrite;
                end
                default: state_d = S_LOAD_HI;
            endcase
        end
    end

    // Capture the next state at the close of ph2.
    always_ff @(negedge ph2) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees pre-edge values regardless of statement order.
        state_p2_q <= state_d;
        count_p2_q <= count_d;
        err_p2_q   <= err_d;
        hi_p2_q    <= hi_d;
    end

    // Publish the captured state on ph1.
    always_ff @(posedge ph1) begin
        state_q <= state_p2_q;
        count_q <= count_p2_q;
        err_q   <= err_p2_q;
        hi_q    <= hi_p2_q;
    end

    // Array writes from the loader or the processor, at the close of ph2.
    always_ff @(negedge ph2) begin
        // NOTE: the array is deliberately not reset; a reset must leave the
        // loaded program intact, and clearing it would cost a full sweep.
        if (ld_wr) begin
            mem_hi[count_q] <= hi_q;
            mem_lo[count_q] <= ld_byte;
        end else if (cpu_wr) begin
            mem_lo[cpu_adr] <= cpu_wdata;
        end
    end

    assign cpu_rdata_hi    = run ? mem_hi[cpu_adr] : '0;
    assign cpu_rdata_lo    = run ? mem_lo[cpu_adr] : '0;
    assign cpu_rdata_lo_oe = run & ~cpu_memwrite;
    assign cpu_hold        = ~run;
    assign ld_ready        = ~run;
    assign ld_count        = count_q;
    assign ld_err          = err_q;

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Self-checking bench for hmmm_mem_responder: directed vector table, a few
// hand-written multi-cycle sequences, and random traffic against a
// behavioural model of the loader/processor memory.
module tb_hmmm_mem_responder;

    logic       ph1, ph2, reset;
    logic [7:0] cpu_adr;
    logic       cpu_memwrite;
    logic [7:0] cpu_wdata;
    logic [6:0] cpu_rdata_hi;
    logic [7:0] cpu_rdata_lo;
    logic       cpu_rdata_lo_oe;
    logic       cpu_hold;
    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_ready;
    logic       ld_done;
    logic [7:0] ld_count;
    logic       ld_err;

    hmmm_mem_responder #(.ADDR_W(8), .WORD_W(15)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .cpu_adr(cpu_adr), .cpu_memwrite(cpu_memwrite), .cpu_wdata(cpu_wdata),
        .cpu_rdata_hi(cpu_rdata_hi), .cpu_rdata_lo(cpu_rdata_lo),
        .cpu_rdata_lo_oe(cpu_rdata_lo_oe), .cpu_hold(cpu_hold),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
        .ld_done(ld_done), .ld_count(ld_count), .ld_err(ld_err)
    );

    // Two-phase nonoverlapping clock, 40 time units per cycle.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #5  ph1 = 1'b1;
            #10 ph1 = 1'b0;
            #10 ph2 = 1'b1;
            #10 ph2 = 1'b0;
            #5;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_run, m_have_hi, m_err;
    logic [6:0] m_hold;
    logic [7:0] m_cnt;
    logic [6:0] m_hi [256];
    logic [7:0] m_lo [256];

    task automatic model_step();
        if (reset) begin
            m_run = 0; m_have_hi = 0; m_cnt = 0; m_err = 0; m_hold = 0;
        end else if (!m_run) begin
            if (ld_valid) begin
                if (!m_have_hi) begin
                    m_hold    = ld_byte[6:0];
                    m_have_hi = 1;
                end else begin
                    m_hi[m_cnt] = m_hold;
                    m_lo[m_cnt] = ld_byte;
                    m_have_hi   = 0;
                    if (m_cnt == 8'd255) begin
                        m_cnt = 0;
                        m_run = 1;
                    end else begin
                        m_cnt = m_cnt + 8'd1;
                    end
                end
            end
            if (ld_done && !m_run) begin
                m_run = 1;
                if (m_have_hi) m_err = 1;
                m_have_hi = 0;
            end
        end else begin
            if (ld_valid) m_err = 1;
            if (cpu_memwrite) m_lo[cpu_adr] = cpu_wdata;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".hold"},  32'(cpu_hold), 32'(!m_run));
        check({tag, ".ready"}, 32'(ld_ready), 32'(!m_run));
        check({tag, ".count"}, 32'(ld_count), 32'(m_cnt));
        check({tag, ".err"},   32'(ld_err),   32'(m_err));
        check({tag, ".rd_hi"}, 32'(cpu_rdata_hi), m_run ? 32'(m_hi[cpu_adr]) : 32'd0);
        check({tag, ".rd_lo"}, 32'(cpu_rdata_lo), m_run ? 32'(m_lo[cpu_adr]) : 32'd0);
        check({tag, ".oe"},    32'(cpu_rdata_lo_oe), 32'(m_run && !cpu_memwrite));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit rst, input bit vld, input logic [7:0] byt, input bit done,
                          input logic [7:0] adr, input bit mw, input logic [7:0] wd);
        reset = rst; ld_valid = vld; ld_byte = byt; ld_done = done;
        cpu_adr = adr; cpu_memwrite = mw; cpu_wdata = wd;
    endtask

    // One full cycle: model follows, DUT captures at ph2 and publishes at ph1.
    task automatic step();
        model_step();
        @(negedge ph2);
        @(negedge ph1);
        #1;
    endtask

    task automatic drive(input bit rst, input bit vld, input logic [7:0] byt, input bit done,
                         input logic [7:0] adr, input bit mw, input logic [7:0] wd);
        set_in(rst, vld, byt, done, adr, mw, wd);
        step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst, vld, done, mw;
        logic [7:0] byt, adr, wd;
        bit         e_hold, e_err, e_oe;
        logic [7:0] e_cnt;
        logic [6:0] e_hi;
        logic [7:0] e_lo;
    } vec_t;

    function automatic vec_t mk(bit rst, bit vld, logic [7:0] byt, bit done, logic [7:0] adr,
                                bit mw, logic [7:0] wd, bit e_hold, logic [7:0] e_cnt,
                                bit e_err, logic [6:0] e_hi, logic [7:0] e_lo, bit e_oe);
        vec_t v;
        v.rst = rst; v.vld = vld; v.byt = byt; v.done = done; v.adr = adr; v.mw = mw; v.wd = wd;
        v.e_hold = e_hold; v.e_cnt = e_cnt; v.e_err = e_err; v.e_hi = e_hi; v.e_lo = e_lo; v.e_oe = e_oe;
        return v;
    endfunction

    vec_t vecs [20];

    logic [7:0] last_hi, last_lo;

    initial begin
        set_in(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);

        // Reset state
        drive(1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        check("reset.hold",  32'(cpu_hold), 32'd1);
        check("reset.ready", 32'(ld_ready), 32'd1);
        check("reset.count", 32'(ld_count), 32'd0);
        check("reset.err",   32'(ld_err),   32'd0);
        check("reset.rd",    {cpu_rdata_hi, cpu_rdata_lo}, 32'd0);
        check("reset.oe",    32'(cpu_rdata_lo_oe), 32'd0);

        // Fill and wrap: 256 words of random bytes
        for (int w = 0; w < 256; w++) begin
            logic [7:0] h, l;
            h = 8'($urandom);
            l = 8'($urandom);
            drive(0, 1, h, 0, 8'h00, 0, 8'h00);
            drive(0, 1, l, 0, 8'h00, 0, 8'h00);
            if (w == 254) check("fill.count255", 32'(ld_count), 32'd255);
            last_hi = h;
            last_lo = l;
        end
        check("fill.count_wrap", 32'(ld_count), 32'd0);
        check("fill.ready",      32'(ld_ready), 32'd0);
        check("fill.hold",       32'(cpu_hold), 32'd0);
        set_in(0, 0, 8'h00, 0, 8'hFF, 0, 8'h00);
        #1;
        check("fill.last_word", {cpu_rdata_hi, cpu_rdata_lo}, {17'd0, last_hi[6:0], last_lo});
        for (int a = 0; a < 256; a++) begin
            cpu_adr = 8'(a);
            #1;
            check("fill.sweep", {cpu_rdata_hi, cpu_rdata_lo}, {17'd0, m_hi[a], m_lo[a]});
        end

        // Directed table: basic program, cpu write, late byte, early done,
        // reset mid-word, ignored writes.
        //             rst vld byt   dn adr   mw wd     hold cnt  err hi     lo     oe
        vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[1]  = mk(0, 1, 8'h0A, 0, 8'h00, 0, 8'h00, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[2]  = mk(0, 1, 8'h21, 0, 8'h00, 0, 8'h00, 1, 8'd1, 0, 7'h00, 8'h00, 0);
        vecs[3]  = mk(0, 1, 8'h58, 0, 8'h00, 0, 8'h00, 1, 8'd1, 0, 7'h00, 8'h00, 0);
        vecs[4]  = mk(0, 1, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'd2, 0, 7'h00, 8'h00, 0);
        vecs[5]  = mk(0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0, 8'd2, 0, 7'h58, 8'h00, 1);
        vecs[6]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'd2, 0, 7'h0A, 8'h21, 1);
        vecs[7]  = mk(0, 0, 8'h00, 0, 8'h01, 1, 8'hAB, 0, 8'd2, 0, 7'h58, 8'hAB, 0);
        vecs[8]  = mk(0, 1, 8'h33, 0, 8'h01, 0, 8'h00, 0, 8'd2, 1, 7'h58, 8'hAB, 1);
        vecs[9]  = mk(0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'd2, 1, 7'h0A, 8'h21, 1);
        vecs[10] = mk(1, 1, 8'h44, 0, 8'h00, 1, 8'hEE, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[11] = mk(0, 1, 8'h11, 0, 8'h00, 0, 8'h00, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[12] = mk(0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'd0, 1, 7'h0A, 8'h21, 1);
        vecs[13] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[14] = mk(0, 1, 8'h55, 0, 8'h00, 0, 8'h00, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[15] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[16] = mk(0, 1, 8'h7F, 0, 8'h01, 1, 8'h99, 1, 8'd0, 0, 7'h00, 8'h00, 0);
        vecs[17] = mk(0, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 8'd1, 0, 7'h00, 8'h00, 0);
        vecs[18] = mk(0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'd1, 0, 7'h7F, 8'hFF, 1);
        vecs[19] = mk(0, 0, 8'h00, 0, 8'h01, 0, 8'h00, 0, 8'd1, 0, 7'h58, 8'hAB, 1);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].byt, vecs[i].done,
                  vecs[i].adr, vecs[i].mw, vecs[i].wd);
            check($sformatf("vec%0d.hold", i),  32'(cpu_hold),  32'(vecs[i].e_hold));
            check($sformatf("vec%0d.ready", i), 32'(ld_ready),  32'(vecs[i].e_hold));
            check($sformatf("vec%0d.count", i), 32'(ld_count),  32'(vecs[i].e_cnt));
            check($sformatf("vec%0d.err", i),   32'(ld_err),    32'(vecs[i].e_err));
            check($sformatf("vec%0d.rd", i),    {cpu_rdata_hi, cpu_rdata_lo},
                  {17'd0, vecs[i].e_hi, vecs[i].e_lo});
            check($sformatf("vec%0d.oe", i),    32'(cpu_rdata_lo_oe), 32'(vecs[i].e_oe));
        end

        // CPU low-byte write with array[5] = 0x1234
        drive(1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        for (int w = 0; w < 6; w++) begin
            drive(0, 1, (w == 5) ? 8'h12 : 8'(w), 0, 8'h00, 0, 8'h00);
            drive(0, 1, (w == 5) ? 8'h34 : 8'(w + 8'h40), 0, 8'h00, 0, 8'h00);
        end
        drive(0, 0, 8'h00, 1, 8'h05, 0, 8'h00);
        check("wr.before", {cpu_rdata_hi, cpu_rdata_lo}, 32'h1234);
        check("wr.count",  32'(ld_count), 32'd6);
        set_in(0, 0, 8'h00, 0, 8'h05, 1, 8'hAB);
        #1;
        check("wr.oe_during", 32'(cpu_rdata_lo_oe), 32'd0);
        step();
        set_in(0, 0, 8'h00, 0, 8'h05, 0, 8'h00);
        #1;
        check("wr.after", {cpu_rdata_hi, cpu_rdata_lo}, 32'h12AB);
        check("wr.oe_after", 32'(cpu_rdata_lo_oe), 32'd1);

        // Random traffic against the model
        for (int c = 0; c < 900; c++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6), 8'($urandom),
                  ($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 9) < 3),
                  8'($urandom));
            check_model($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
